// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and helpers for the ROM download path: queue entry layout,
// queue depth and the priority region decode.
package jtframe_dwnld_pkg;

  localparam int QDEPTH      = 2;
  localparam int MAX_AW      = 32;
  localparam int MAX_REGIONS = 8;
  localparam int WADDR_W     = MAX_AW - 1;

  // One pending SDRAM write; the address field is sized for the widest AW
  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [15:0]        data;
    logic [1:0]         mask;
  } prog_entry_t;

  // Highest region whose start is <= addr; region 0 when nothing matches
  function automatic logic [2:0] region_of(
    input logic [MAX_AW-1:0]             addr,
    input logic [MAX_REGIONS*MAX_AW-1:0] starts,
    input int                            regions
  );
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < MAX_REGIONS; i++) begin
      if ((i < regions) && (addr >= starts[i*MAX_AW +: MAX_AW])) begin
        r = 3'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/jtframe_dwnld_if.sv
// Download bus: ioctl byte stream in, SDRAM programming port and PROM
// side-port out, plus download status.
interface jtframe_dwnld_if #(
  parameter int AW = 22
);
  logic          downloading;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic          ioctl_wait;
  logic [AW-2:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic          prog_we;
  logic          prog_rdy;
  logic          prom_we;
  logic [7:0]    prom_addr;
  logic [7:0]    prom_data;
  logic          dwnld_busy;
  logic          dwnld_done;
  logic          overflow;

  modport master (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
    input  ioctl_wait, prog_addr, prog_data, prog_mask, prog_we,
           prom_we, prom_addr, prom_data, dwnld_busy, dwnld_done, overflow
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
    output ioctl_wait, prog_addr, prog_data, prog_mask, prog_we,
           prom_we, prom_addr, prom_data, dwnld_busy, dwnld_done, overflow
  );
endinterface

// File: rtl/jtframe_dwnld_fifo.sv
// Two-entry first-word-fall-through write queue. A push on a full queue is
// taken only when a pop happens in the same cycle.
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  prog_entry_t din,
  output prog_entry_t head,
  output logic [1:0]  count
);

  prog_entry_t mem_r [QDEPTH];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;
  logic        do_push_s;
  logic        do_pop_s;

  // Qualify push/pop against the current occupancy
  always_comb begin
    do_pop_s  = pop & (count_r != 2'd0);
    do_push_s = push & ((count_r != 2'd2) | do_pop_s);
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) wr_ptr_r <= ~wr_ptr_r;
      if (do_pop_s)  rd_ptr_r <= ~rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/jtframe_dwnld_mux.sv
// ROM download mux: remaps ioctl bytes into SDRAM word writes through a
// two-entry queue, diverts the top of the address space to the PROM port,
// and reports download activity.
module jtframe_dwnld_mux
  import jtframe_dwnld_pkg::*;
#(
  parameter int                    AW         = 22,
  parameter int                    REGIONS    = 4,
  parameter logic [REGIONS*AW-1:0] REG_START  = {22'h30_0000, 22'h20_0000, 22'h08_0000, 22'h00_0000},
  parameter logic [REGIONS*AW-1:0] REG_OFFSET = {22'h30_0000, 22'h20_0000, 22'h10_0000, 22'h00_0000},
  parameter logic [AW-1:0]         PROM_START = 22'h3F_FF00,
  parameter bit                    SWAB       = 1'b0
)(
  input logic           clk,
  input logic           rst,
  jtframe_dwnld_if.slave ctl
);

  typedef enum logic [0:0] { ST_IDLE = 1'b0, ST_ISSUE = 1'b1 } state_t;

  state_t                        state_r, state_nx_s;
  logic [MAX_REGIONS*MAX_AW-1:0] starts_s;
  logic [2:0]                    region_s;
  logic [AW-1:0]                 byte_s;
  logic                          is_prom_s, push_req_s, push_ok_s, pop_s;
  prog_entry_t                   entry_s, head_s;
  logic [1:0]                    count_s;
  logic [AW-2:0]                 prog_addr_r, prog_addr_nx_s;
  logic [15:0]                   prog_data_r, prog_data_nx_s;
  logic [1:0]                    prog_mask_r, prog_mask_nx_s;
  logic                          prog_we_r, prog_we_nx_s;
  logic                          prom_we_r;
  logic [7:0]                    prom_addr_r, prom_data_r;
  logic                          busy_r, busy_nx_s, done_r, overflow_r;

  // Region starts widened into the fixed-size table the decode helper expects
  for (genvar gi = 0; gi < MAX_REGIONS; gi++) begin : g_starts
    if (gi < REGIONS) begin : g_used
      assign starts_s[gi*MAX_AW +: MAX_AW] = MAX_AW'(REG_START[gi*AW +: AW]);
    end else begin : g_unused
      assign starts_s[gi*MAX_AW +: MAX_AW] = '0;
    end
  end

  // Address remap, byte lane selection and push/pop qualification
  always_comb begin
    region_s      = region_of(MAX_AW'(ctl.ioctl_addr), starts_s, REGIONS);
    byte_s        = ctl.ioctl_addr - REG_START[int'(region_s)*AW +: AW]
                                   + REG_OFFSET[int'(region_s)*AW +: AW];
    entry_s.addr  = WADDR_W'(byte_s[AW-1:1]);
    entry_s.data  = {ctl.ioctl_data, ctl.ioctl_data};
    entry_s.mask  = (byte_s[0] ^ SWAB) ? 2'b01 : 2'b10;
    is_prom_s     = (ctl.ioctl_addr >= PROM_START);
    push_req_s    = ctl.ioctl_wr & ~is_prom_s;
    pop_s         = (state_r == ST_ISSUE) & ctl.prog_rdy;
    push_ok_s     = push_req_s & ((count_s != 2'd2) | pop_s);
    busy_nx_s     = ctl.downloading | (count_s != 2'd0) | prog_we_r;
  end

  jtframe_dwnld_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok_s),
    .pop   (pop_s),
    .din   (entry_s),
    .head  (head_s),
    .count (count_s)
  );

  // SDRAM request sequencing: load the queue head, then hold it until acked
  always_comb begin
    state_nx_s     = state_r;
    prog_addr_nx_s = prog_addr_r;
    prog_data_nx_s = prog_data_r;
    prog_mask_nx_s = prog_mask_r;
    prog_we_nx_s   = prog_we_r;
    case (state_r)
      ST_IDLE: begin
        if (count_s != 2'd0) begin
          prog_addr_nx_s = head_s.addr[AW-2:0];
          prog_data_nx_s = head_s.data;
          prog_mask_nx_s = head_s.mask;
          prog_we_nx_s   = 1'b1;
          state_nx_s     = ST_ISSUE;
        end else begin
          prog_we_nx_s   = 1'b0;
          state_nx_s     = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (ctl.prog_rdy) begin
          prog_we_nx_s = 1'b0;
          state_nx_s   = ST_IDLE;
        end else begin
          prog_we_nx_s = 1'b1;
          state_nx_s   = ST_ISSUE;
        end
      end
      default: begin
        prog_we_nx_s = 1'b0;
        state_nx_s   = ST_IDLE;
      end
    endcase
  end

  // FSM state and programming-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      prog_addr_r <= '0;
      prog_data_r <= 16'h0000;
      prog_mask_r <= 2'b00;
      prog_we_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      prog_addr_r <= prog_addr_nx_s;
      prog_data_r <= prog_data_nx_s;
      prog_mask_r <= prog_mask_nx_s;
      prog_we_r   <= prog_we_nx_s;
    end
  end

  // PROM side-port, busy/done tracking and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prom_we_r   <= 1'b0;
      prom_addr_r <= 8'h00;
      prom_data_r <= 8'h00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      prom_we_r <= ctl.ioctl_wr & is_prom_s;
      if (ctl.ioctl_wr & is_prom_s) begin
        prom_addr_r <= ctl.ioctl_addr[7:0];
        prom_data_r <= ctl.ioctl_data;
      end
      busy_r     <= busy_nx_s;
      done_r     <= busy_r & ~busy_nx_s;
      overflow_r <= overflow_r | (push_req_s & ~push_ok_s);
    end
  end

  assign ctl.ioctl_wait = (count_s == 2'd2);
  assign ctl.prog_addr  = prog_addr_r;
  assign ctl.prog_data  = prog_data_r;
  assign ctl.prog_mask  = prog_mask_r;
  assign ctl.prog_we    = prog_we_r;
  assign ctl.prom_we    = prom_we_r;
  assign ctl.prom_addr  = prom_addr_r;
  assign ctl.prom_data  = prom_data_r;
  assign ctl.dwnld_busy = busy_r;
  assign ctl.dwnld_done = done_r;
  assign ctl.overflow   = overflow_r;

endmodule
